// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register for the RV32I 5-stage
//   core. Owns the PC, the PC+4 incrementer, the redirect mux, a latch that
//   remembers a redirect arriving while the pipe is stalled, and the IF/ID
//   register with stall and flush.
//
// Parameters
//   RESET_PC          PC value loaded on reset
//   NOP_INSTR         bubble instruction (addi x0,x0,0) used on flush/reset
//
// Ports
//   clk               core clock, all state on rising edge
//   rst               asynchronous, active-high reset
//   stall             hazard-unit stall; holds PC and IF/ID
//   pcsrc             taken branch/jump from the EX-stage branch unit
//   branch_target     redirect address from the EX adder
//   imem_addr         instruction memory address (combinational read)
//   imem_rdata        instruction word for imem_addr, same cycle
//   instr_d           IF/ID instruction
//   pc_d              IF/ID PC
//   pc_plus4_d        IF/ID PC+4 (link value for JAL/JALR)
//   valid_d           IF/ID holds a real fetched instruction
//   redirect_pending  a redirect is latched, waiting for stall release
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        redirect_pending
);

  // Instructions are word aligned; low address bits of a target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic        pend_vld;
  logic [31:0] pend_target;

  logic        redir;
  logic [31:0] redir_target;
  logic        flush;

  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc_plus4_p1;
  logic        vld_p1;

  // ---- stage p0: fetch (PC, incrementer, redirect mux) ----
  assign pc_plus4_p0  = pc_p0 + 32'd4;
  assign redir        = pcsrc | pend_vld;
  // A live branch from EX is younger than anything latched, so it wins.
  assign redir_target = pcsrc ? align_word(branch_target) : pend_target;
  // Squash the wrong-path instruction whenever a redirect takes effect; a
  // live pcsrc flushes even under stall so the pending latch cannot leave a
  // stale wrong-path instruction sitting in decode.
  assign flush        = pcsrc | (pend_vld & ~stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0       <= RESET_PC;
      pend_vld    <= 1'b0;
      pend_target <= 32'd0;
    end else if (stall) begin
      // PC frozen; remember the newest redirect until the stall releases.
      if (pcsrc) begin
        pend_vld    <= 1'b1;
        pend_target <= align_word(branch_target);
      end
    end else if (redir) begin
      pc_p0    <= redir_target;
      pend_vld <= 1'b0;
    end else begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= 32'd0;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
    end else if (flush) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= 32'd0;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
    end else if (!stall) begin
      instr_p1    <= imem_rdata;
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= 1'b1;
    end
  end

  assign imem_addr        = pc_p0;
  assign instr_d          = instr_p1;
  assign pc_d             = pc_p1;
  assign pc_plus4_d       = pc_plus4_p1;
  assign valid_d          = vld_p1;
  assign redirect_pending = pend_vld;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;

  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, redirect_pending;

  logic [31:0] w_imem_addr, w_imem_rdata;
  logic [31:0] w_instr_d, w_pc_d, w_pc_plus4_d;
  logic        w_valid_d, w_redirect_pending;

  int n_chk;
  int n_err;

  // Reference model: architectural view of the fetch unit
  logic [31:0] m_pc, m_pt, m_instr, m_pcd, m_pc4d;
  logic        m_pv, m_vld;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata   = memf(imem_addr);
  assign w_imem_rdata = memf(w_imem_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .redirect_pending(redirect_pending)
  );

  // Second instance free-runs from the top of the address space to check wrap.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .pcsrc(1'b0),
    .branch_target(32'd0),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .instr_d(w_instr_d), .pc_d(w_pc_d), .pc_plus4_d(w_pc_plus4_d),
    .valid_d(w_valid_d), .redirect_pending(w_redirect_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_pv = 1'b0; m_pt = 32'd0;
    m_instr = NOP; m_pcd = 32'd0; m_pc4d = 32'd0; m_vld = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".instr_d"}, instr_d, m_instr);
    chk({tag, ".pc_d"}, pc_d, m_pcd);
    chk({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4d);
    chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, m_vld});
    chk({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, m_pv});
  endtask

  // Predict one clock edge from the architectural rules, then compare.
  task automatic cycle(input logic s, input logic p, input logic [31:0] bt, input string tag);
    logic [31:0] tgt;
    stall = s; pcsrc = p; branch_target = bt;
    tgt = bt & ~32'd3;
    // decode register sees the old fetch state
    if (p || (m_pv && !s)) begin
      m_instr = NOP; m_pcd = 32'd0; m_pc4d = 32'd0; m_vld = 1'b0;
    end else if (!s) begin
      m_instr = memf(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_vld = 1'b1;
    end
    if (s) begin
      if (p) begin m_pv = 1'b1; m_pt = tgt; end
    end else if (p) begin
      m_pc = tgt; m_pv = 1'b0;
    end else if (m_pv) begin
      m_pc = m_pt; m_pv = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must change with no clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b0; stall = 1'b0; pcsrc = 1'b0; branch_target = 32'd0;
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("wrap.reset_addr", w_imem_addr, 32'hFFFF_FFFC);
    rst = 1'b0;

    // Free run 0,4,8,C,10
    cycle(0, 0, 0, "run1");
    chk("wrap.addr0", w_imem_addr, 32'h0000_0000);
    chk("wrap.pc_d", w_pc_d, 32'hFFFF_FFFC);
    chk("wrap.pc4_d", w_pc_plus4_d, 32'h0000_0000);
    chk("first.valid", {31'd0, valid_d}, 32'd1);
    chk("first.instr", instr_d, memf(32'h0));
    cycle(0, 0, 0, "run2");
    cycle(0, 0, 0, "run3");
    cycle(0, 0, 0, "run4");
    chk("run.addr10", imem_addr, 32'h10);

    // Taken branch to 0x40
    cycle(0, 1, 32'h40, "br");
    chk("br.addr", imem_addr, 32'h40);
    chk("br.instr_nop", instr_d, NOP);
    chk("br.valid0", {31'd0, valid_d}, 32'd0);
    cycle(0, 0, 0, "br2");
    chk("br2.instr", instr_d, memf(32'h40));
    chk("br2.pc_d", pc_d, 32'h40);
    chk("br2.pc4_d", pc_plus4_d, 32'h44);

    // Stall at 0x08
    async_reset("rst2");
    cycle(0, 0, 0, "s0");
    cycle(0, 0, 0, "s1");
    cycle(1, 0, 0, "stall1");
    cycle(1, 0, 0, "stall2");
    chk("stall.addr", imem_addr, 32'h08);
    chk("stall.pc_d", pc_d, 32'h04);
    cycle(0, 0, 0, "unstall");
    chk("unstall.addr", imem_addr, 32'h0C);

    // Redirect during stall
    cycle(1, 1, 32'h80, "rds");
    chk("rds.addr_hold", imem_addr, 32'h0C);
    chk("rds.pending", {31'd0, redirect_pending}, 32'd1);
    chk("rds.instr_nop", instr_d, NOP);
    cycle(1, 0, 0, "rds_hold");
    cycle(0, 0, 0, "rds_rel");
    chk("rds_rel.addr", imem_addr, 32'h80);
    chk("rds_rel.pending", {31'd0, redirect_pending}, 32'd0);
    chk("rds_rel.instr_nop", instr_d, NOP);

    // Newer redirect during stall overwrites the pending one; live beats pending
    cycle(1, 1, 32'h200, "ovr1");
    cycle(1, 1, 32'h300, "ovr2");
    cycle(0, 1, 32'h404, "ovr_live");
    chk("ovr_live.addr", imem_addr, 32'h404);

    // Misaligned target
    cycle(0, 1, 32'h123, "mis");
    chk("mis.addr", imem_addr, 32'h120);
    cycle(0, 0, 0, "mis2");

    // Async reset while a redirect is pending
    cycle(1, 1, 32'h500, "pend");
    async_reset("arst_pend");
    chk("arst.instr", instr_d, NOP);
    cycle(0, 0, 0, "post1");
    cycle(0, 0, 0, "post2");
    // Async reset while decode holds a valid instruction
    async_reset("arst_valid");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
